// File: rtl/sweep_pkg.sv
// Shared types for the raster sweep controller.
// Mode and FSM state encodings.
package sweep_pkg;

  typedef enum logic [1:0] {
    X_SWEEP  = 2'd0,
    Y_SWEEP  = 2'd1,
    DIAGONAL = 2'd2,
    RASTER   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/sweep_prescaler.sv
// Step-rate divider: counts 0..div while run is high.
// tick marks the last cycle of each step period.
module sweep_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = run && (cnt == div);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sweep_controller.sv
// Sweep controller: FSM, raster step/line counters and
// registered enable pulses for two triangle generators.
module sweep_controller
  import sweep_pkg::*;
#(
  parameter int N     = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  output logic             ena_x,
  output logic             ena_y,
  output logic             busy,
  output logic             done
);

  localparam logic [N-1:0] MAX = '1;

  state_t           state;
  state_t           state_nx;
  mode_t            mode_q;
  logic [DIV_W-1:0] div_q;
  logic [N-1:0]     xcnt;
  logic [N-1:0]     line_cnt;
  logic             launch;
  logic             frame_end;
  logic             run;
  logic             tick;

  assign launch = ((state == IDLE) || (state == DONE))
               && start && !stop && !pause;

  // Counters sit at MAX/MAX only after the last x-step of a frame.
  assign frame_end = (mode_q == RASTER)
                  && (xcnt == MAX) && (line_cnt == MAX);

  assign run = (state == RUN) && !stop && !pause && !frame_end;

  sweep_prescaler #(
    .DIV_W(DIV_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .clear(launch),
    .div  (div_q),
    .tick (tick)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (launch) state_nx = RUN;
      end
      RUN: begin
        if (stop)           state_nx = IDLE;
        else if (pause)     state_nx = PAUSED;
        else if (frame_end) state_nx = DONE;
      end
      PAUSED: begin
        if (stop)        state_nx = IDLE;
        else if (!pause) state_nx = RUN;
      end
      DONE: begin
        if (stop)        state_nx = IDLE;
        else if (launch) state_nx = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      ena_x    <= 1'b0;
      ena_y    <= 1'b0;
      mode_q   <= X_SWEEP;
      div_q    <= '0;
      xcnt     <= '0;
      line_cnt <= '0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == RUN) || (state_nx == PAUSED);
      done  <= (state_nx == DONE);
      ena_x <= 1'b0;
      ena_y <= 1'b0;
      if (launch) begin
        mode_q   <= mode_t'(mode);
        div_q    <= div;
        xcnt     <= '0;
        line_cnt <= '0;
      end
      if (tick) begin
        unique case (mode_q)
          X_SWEEP: ena_x <= 1'b1;
          Y_SWEEP: ena_y <= 1'b1;
          DIAGONAL: begin
            ena_x <= 1'b1;
            ena_y <= 1'b1;
          end
          RASTER: begin
            if (xcnt == MAX) begin
              ena_y    <= 1'b1;
              xcnt     <= '0;
              line_cnt <= line_cnt + 1'b1;
            end else begin
              ena_x <= 1'b1;
              xcnt  <= xcnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sweep_controller.sv
// Scoreboard bench for sweep_controller (N=2, MAX=3).
// Expected pulse streams come from a per-mode pulse model.
module tb_sweep_controller;

  localparam int N      = 2;
  localparam int DW     = 8;
  localparam int MAX    = 3;
  localparam int FRAME  = MAX * (MAX + 2);
  localparam int NO_LIM = 1 << 30;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          pause = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [DW-1:0] div = '0;
  logic          ena_x;
  logic          ena_y;
  logic          busy;
  logic          done;

  sweep_controller #(
    .N    (N),
    .DIV_W(DW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .stop (stop),
    .pause(pause),
    .mode (mode),
    .div  (div),
    .ena_x(ena_x),
    .ena_y(ena_y),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit x;
    bit y;
    int t;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Pulse k of a sweep in mode m, as {x,y}.
  function automatic bit [1:0] kind(int m, int k);
    case (m)
      0: return 2'b10;
      1: return 2'b01;
      2: return 2'b11;
      default: return ((k % (MAX + 1)) == MAX) ? 2'b01 : 2'b10;
    endcase
  endfunction

  // Pulse k appears (k+1)*(d+1) cycles after the start edge e0.
  function automatic void push_pulses(int m, int d, int e0,
                                      int k_hi, int t_lim,
                                      int untimed_from);
    for (int k = 0; k <= k_hi; k++) begin
      exp_t e;
      bit [1:0] v;
      int t;
      t = e0 + (k + 1) * (d + 1);
      if (t > t_lim) break;
      v = kind(m, k);
      e.x = v[1];
      e.y = v[0];
      e.t = (k >= untimed_from) ? -1 : t;
      exp_q.push_back(e);
    end
  endfunction

  task automatic chk(string nm, int got, int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (ena_x || ena_y) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse cyc=%0d got x=%0b y=%0b want none",
                 cyc, ena_x, ena_y);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (ena_x !== e.x || ena_y !== e.y || (e.t >= 0 && e.t != cyc)) begin
          miscompares++;
          $display("FAIL pulse cyc=%0d got x=%0b y=%0b want x=%0b y=%0b t=%0d",
                   cyc, ena_x, ena_y, e.x, e.y, e.t);
        end
      end
    end
  end

  task automatic drain_check(string nm);
    repeat (4) @(negedge clk);
    chk(nm, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Continuous sweep stopped after r cycles of RUN.
  task automatic run_cont(int m, int d, int r, bit all3);
    int e0;
    int es;
    @(negedge clk);
    mode = 2'(m);
    div = DW'(d);
    start = 1'b1;
    e0 = cyc + 1;
    es = e0 + r + 1;
    push_pulses(m, d, e0, 100000, es - 1, NO_LIM);
    @(negedge clk);
    start = 1'b0;
    chk("busy_run", busy, 1);
    repeat (r) begin
      @(negedge clk);
      mode = 2'($urandom);
      div = DW'($urandom);
    end
    chk("busy_before_stop", busy, 1);
    stop = 1'b1;
    start = all3;
    pause = all3;
    @(negedge clk);
    stop = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    chk("busy_after_stop", busy, 0);
    chk("done_after_stop", done, 0);
    drain_check("cont_drain");
  endtask

  // Full raster frame; optional pause after pulse number pause_after.
  task automatic run_raster(int d, int pause_after);
    int e0;
    int last_t;
    int n;
    bit timed;
    timed = (pause_after >= FRAME);
    @(negedge clk);
    mode = 2'd3;
    div = DW'(d);
    start = 1'b1;
    e0 = cyc + 1;
    last_t = e0 + FRAME * (d + 1);
    push_pulses(3, d, e0, FRAME - 1, NO_LIM, pause_after);
    @(negedge clk);
    start = 1'b0;
    if (!timed) begin
      while (cyc < e0 + pause_after * (d + 1)) @(negedge clk);
      pause = 1'b1;
      repeat (10) begin
        @(negedge clk);
        chk("paused_no_pulse", int'(ena_x | ena_y), 0);
        chk("paused_busy", busy, 1);
      end
      pause = 1'b0;
    end else begin
      while (cyc < last_t) begin
        @(negedge clk);
        mode = 2'($urandom);
        div = DW'($urandom);
      end
    end
    n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", done, 1);
    chk("busy_in_done", busy, 0);
    if (timed) chk("done_cycle", cyc, last_t + 1);
    chk("raster_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int e0;
    int r;
    @(negedge clk);
    chk("rst_ena_x", ena_x, 0);
    chk("rst_ena_y", ena_y, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic raster frame, then DONE holds, then restart with div=1.
    run_raster(0, FRAME);
    drain_check("done_hold_drain");
    chk("done_hold", done, 1);
    run_raster(1, FRAME);

    // Stop from DONE returns to IDLE.
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("done_stop", done, 0);

    run_cont(0, 3, 17, 1'b0);
    run_cont(1, 0, 6, 1'b0);
    run_cont(2, 1, 9, 1'b0);
    for (int i = 0; i < 6; i++) begin
      run_cont($urandom_range(0, 2), $urandom_range(0, 3),
               $urandom_range(1, 20), 1'b0);
    end

    // start+pause+stop together while running.
    run_cont(0, 0, 3, 1'b1);

    // start+stop together while idle.
    @(negedge clk);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    chk("idle_start_stop_busy", busy, 0);
    drain_check("idle_start_stop_drain");

    // Pause mid-frame.
    run_raster(0, 5);
    run_raster($urandom_range(0, 2), $urandom_range(1, FRAME - 1));

    // Reset mid diagonal sweep.
    r = $urandom_range(3, 8);
    @(negedge clk);
    mode = 2'd2;
    div = '0;
    start = 1'b1;
    e0 = cyc + 1;
    push_pulses(2, 0, e0, 100000, e0 + r, NO_LIM);
    @(negedge clk);
    start = 1'b0;
    repeat (r) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_ena_x", ena_x, 0);
    chk("async_rst_ena_y", ena_y, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    drain_check("post_rst_drain");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
